// File: rtl/apb_cfg_pkg.sv
// Shared types for the APB configuration initiator: FSM state encoding,
// response record and the word-alignment helper.
package apb_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_cfg_state_e;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        timeout;
    } apb_cfg_rsp_t;

    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb == 2'b00);
    endfunction

endpackage

// File: rtl/apb_cfg_initiator_if.sv
// APB3 bus bundle between the configuration initiator (master) and a
// completer (slave).
interface apb_cfg_initiator_if #(
    parameter int APB_ADDR_WIDTH = 12
);
    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic [31:0]               PWDATA;
    logic                      PWRITE;
    logic                      PSEL;
    logic                      PENABLE;
    logic [31:0]               PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_cfg_initiator.sv
// Single-outstanding APB initiator: turns one request into one APB transfer
// and returns one response, with alignment check and wait-state timeout.
module apb_cfg_initiator
    import apb_cfg_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]               req_wdata_i,
    input  logic                      req_write_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [31:0]               rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic                      rsp_timeout_o,
    output logic                      busy_o,
    apb_cfg_initiator_if.master       apb
);

    localparam int                CNT_W   = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT_CYCLES);
    localparam bit                TO_EN   = (TIMEOUT_CYCLES != 0);

    apb_cfg_state_e              state_r;
    apb_cfg_state_e              state_nxt_s;
    logic [CNT_W-1:0]            cnt_r;
    logic [CNT_W-1:0]            cnt_nxt_s;
    logic [CNT_W-1:0]            cnt_inc_s;
    apb_cfg_rsp_t                rsp_r;
    apb_cfg_rsp_t                rsp_nxt_s;
    logic                        latch_s;

    logic [APB_ADDR_WIDTH-1:0]   addr_r;
    logic [31:0]                 wdata_r;
    logic                        write_r;
    logic                        psel_r;
    logic                        penable_r;
    logic                        busy_r;
    logic                        req_ready_r;
    logic                        rsp_valid_r;

    // Next-state, wait counter and response capture.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        rsp_nxt_s   = rsp_r;
        latch_s     = 1'b0;
        cnt_inc_s   = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_W'(1));

        case (state_r)
            ST_IDLE: begin
                if (req_valid_i) begin
                    if (is_word_aligned(req_addr_i[1:0])) begin
                        state_nxt_s = ST_SETUP;
                        latch_s     = 1'b1;
                    end else begin
                        // Misaligned requests never reach the bus.
                        state_nxt_s       = ST_RESP;
                        rsp_nxt_s.rdata   = 32'h0;
                        rsp_nxt_s.err     = 1'b1;
                        rsp_nxt_s.timeout = 1'b0;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_nxt_s = ST_ACCESS;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
            ST_ACCESS: begin
                if (apb.PREADY) begin
                    state_nxt_s       = ST_RESP;
                    rsp_nxt_s.err     = apb.PSLVERR;
                    rsp_nxt_s.timeout = 1'b0;
                    rsp_nxt_s.rdata   = (!write_r && !apb.PSLVERR) ? apb.PRDATA : 32'h0;
                end else begin
                    cnt_nxt_s = cnt_inc_s;
                    if (TO_EN && (cnt_inc_s >= TO_LIM)) begin
                        state_nxt_s       = ST_RESP;
                        rsp_nxt_s.rdata   = 32'h0;
                        rsp_nxt_s.err     = 1'b1;
                        rsp_nxt_s.timeout = 1'b1;
                    end else begin
                        state_nxt_s = ST_ACCESS;
                    end
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Counter, captured request and response record.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            cnt_r   <= {CNT_W{1'b0}};
            rsp_r   <= '{rdata: 32'h0, err: 1'b0, timeout: 1'b0};
            addr_r  <= {APB_ADDR_WIDTH{1'b0}};
            wdata_r <= 32'h0;
            write_r <= 1'b0;
        end else begin
            cnt_r <= cnt_nxt_s;
            rsp_r <= rsp_nxt_s;
            if (latch_s) begin
                addr_r  <= req_addr_i;
                wdata_r <= req_wdata_i;
                write_r <= req_write_i;
            end
        end
    end

    // Control outputs registered from the next state so they align with it.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            psel_r      <= 1'b0;
            penable_r   <= 1'b0;
            busy_r      <= 1'b0;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
        end else begin
            psel_r      <= (state_nxt_s == ST_SETUP) || (state_nxt_s == ST_ACCESS);
            penable_r   <= (state_nxt_s == ST_ACCESS);
            busy_r      <= (state_nxt_s != ST_IDLE);
            req_ready_r <= (state_nxt_s == ST_IDLE);
            rsp_valid_r <= (state_nxt_s == ST_RESP);
        end
    end

    assign apb.PADDR   = addr_r;
    assign apb.PWDATA  = wdata_r;
    assign apb.PWRITE  = write_r;
    assign apb.PSEL    = psel_r;
    assign apb.PENABLE = penable_r;

    assign req_ready_o   = req_ready_r;
    assign busy_o        = busy_r;
    assign rsp_valid_o   = rsp_valid_r;
    assign rsp_rdata_o   = rsp_r.rdata;
    assign rsp_err_o     = rsp_r.err;
    assign rsp_timeout_o = rsp_r.timeout;

endmodule

// File: tb/tb_apb_cfg_initiator.sv
// Randomised bench for apb_cfg_initiator: every transfer's bus phases and
// response are predicted from the transfer rules and compared cycle by cycle.
module tb_apb_cfg_initiator;

    localparam int AW = 12;
    localparam int TO = 4;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [AW-1:0] req_addr_i;
    logic [31:0]   req_wdata_i;
    logic          req_write_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [31:0]   rsp_rdata_o;
    logic          rsp_err_o;
    logic          rsp_timeout_o;
    logic          busy_o;

    int tests_run    = 0;
    int tests_failed = 0;

    apb_cfg_initiator_if #(.APB_ADDR_WIDTH(AW)) apb ();

    apb_cfg_initiator #(
        .APB_ADDR_WIDTH (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .HCLK          (HCLK),
        .HRESET        (HRESET),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_addr_i    (req_addr_i),
        .req_wdata_i   (req_wdata_i),
        .req_write_i   (req_write_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_rdata_o   (rsp_rdata_o),
        .rsp_err_o     (rsp_err_o),
        .rsp_timeout_o (rsp_timeout_o),
        .busy_o        (busy_o),
        .apb           (apb.master)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One transfer. Cycle k counts from the accept cycle T (k=0); the expected
    // phase windows follow from the transfer rules: SETUP at T+1, ACCESS from
    // T+2 for waits+1 cycles (or TO cycles on timeout), response afterwards.
    task automatic do_txn(input logic [AW-1:0] addr, input logic [31:0] wdata,
                          input logic write, input int waits, input logic slverr,
                          input logic [31:0] prdata, input int rdly);
        bit          mis, tmo, e_psel, e_pen, e_rv;
        int          last, rfirst, rdone;
        logic        e_err;
        logic [31:0] e_rd;
        mis    = (addr[1:0] != 2'b00);
        tmo    = !mis && (waits >= TO);
        last   = mis ? 0 : (tmo ? 1 + TO : 2 + waits);
        rfirst = mis ? 1 : last + 1;
        rdone  = rfirst + rdly;
        e_err  = mis || tmo || slverr;
        e_rd   = (!write && !e_err) ? prdata : 32'h0;

        @(negedge HCLK);
        chk("idle_ready", {31'h0, req_ready_o}, 32'h1);
        chk("idle_busy", {31'h0, busy_o}, 32'h0);
        req_valid_i = 1'b1;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        req_write_i = write;
        rsp_ready_i = 1'($urandom);
        apb.PREADY  = 1'($urandom);
        apb.PSLVERR = 1'($urandom);
        apb.PRDATA  = $urandom;

        for (int k = 1; k <= rdone + 1; k++) begin
            @(negedge HCLK);
            req_valid_i = 1'($urandom_range(0, 3) == 0);
            req_addr_i  = AW'($urandom);
            e_psel = !mis && (k <= last);
            e_pen  = !mis && (k >= 2) && (k <= last);
            e_rv   = (k >= rfirst) && (k <= rdone);
            chk("psel", {31'h0, apb.PSEL}, {31'h0, e_psel});
            chk("penable", {31'h0, apb.PENABLE}, {31'h0, e_pen});
            chk("rsp_valid", {31'h0, rsp_valid_o}, {31'h0, e_rv});
            chk("req_ready", {31'h0, req_ready_o}, {31'h0, (k > rdone)});
            chk("busy", {31'h0, busy_o}, {31'h0, (k <= rdone)});
            if (e_psel) begin
                chk("paddr", {20'h0, apb.PADDR}, {20'h0, addr});
                chk("pwrite", {31'h0, apb.PWRITE}, {31'h0, write});
                chk("pwdata", apb.PWDATA, wdata);
            end
            if (e_rv) begin
                chk("rsp_rdata", rsp_rdata_o, e_rd);
                chk("rsp_err", {31'h0, rsp_err_o}, {31'h0, e_err});
                chk("rsp_timeout", {31'h0, rsp_timeout_o}, {31'h0, tmo});
            end
            if (e_pen && !tmo && (k == 2 + waits)) begin
                apb.PREADY  = 1'b1;
                apb.PSLVERR = slverr;
                apb.PRDATA  = prdata;
            end else if (e_pen) begin
                apb.PREADY  = 1'b0;
                apb.PSLVERR = 1'($urandom);
                apb.PRDATA  = $urandom;
            end else begin
                apb.PREADY  = 1'($urandom);
                apb.PSLVERR = 1'($urandom);
                apb.PRDATA  = $urandom;
            end
            if (k < rfirst) rsp_ready_i = 1'($urandom);
            else            rsp_ready_i = (k == rdone);
        end
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESET      = 1'b1;
        req_valid_i = 1'b0;
        req_addr_i  = '0;
        req_wdata_i = 32'h0;
        req_write_i = 1'b0;
        rsp_ready_i = 1'b0;
        apb.PREADY  = 1'b0;
        apb.PSLVERR = 1'b0;
        apb.PRDATA  = 32'h0;
        repeat (2) @(negedge HCLK);
        chk("rst_psel", {31'h0, apb.PSEL}, 32'h0);
        chk("rst_penable", {31'h0, apb.PENABLE}, 32'h0);
        chk("rst_pwrite", {31'h0, apb.PWRITE}, 32'h0);
        chk("rst_paddr", {20'h0, apb.PADDR}, 32'h0);
        chk("rst_pwdata", apb.PWDATA, 32'h0);
        chk("rst_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
        chk("rst_rdata", rsp_rdata_o, 32'h0);
        chk("rst_err", {31'h0, rsp_err_o}, 32'h0);
        chk("rst_timeout", {31'h0, rsp_timeout_o}, 32'h0);
        chk("rst_busy", {31'h0, busy_o}, 32'h0);
        HRESET = 1'b0;
        @(negedge HCLK);
        chk("rst_ready", {31'h0, req_ready_o}, 32'h1);

        // Directed: zero-wait write, waited read, slave error, timeout, misaligned.
        do_txn(12'h004, 32'hDEADBEEF, 1'b1, 0, 1'b0, 32'h12345678, 0);
        do_txn(12'h0C4, 32'h0,        1'b0, 3, 1'b0, 32'h1A000080, 1);
        do_txn(12'h010, 32'h0,        1'b0, 1, 1'b1, 32'hCAFEF00D, 0);
        do_txn(12'h020, 32'h55AA55AA, 1'b0, 50, 1'b0, 32'h0BADBEEF, 2);
        do_txn(12'h006, 32'h11111111, 1'b1, 0, 1'b0, 32'h0, 10);
        do_txn(12'h3FC, 32'h0,        1'b0, TO - 1, 1'b0, 32'hFEEDFACE, 0);

        for (int n = 0; n < 60; n++) begin
            logic [AW-1:0] a;
            a = AW'($urandom);
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            do_txn(a, $urandom, 1'($urandom), int'($urandom_range(0, TO + 1)),
                   1'($urandom_range(0, 3) == 0), $urandom, int'($urandom_range(0, 3)));
        end

        // Reset while in ACCESS drops the bus at once and reports nothing.
        @(negedge HCLK);
        req_valid_i = 1'b1;
        req_addr_i  = 12'h100;
        req_write_i = 1'b0;
        apb.PREADY  = 1'b0;
        @(negedge HCLK);
        req_valid_i = 1'b0;
        @(negedge HCLK);
        chk("pre_rst_penable", {31'h0, apb.PENABLE}, 32'h1);
        #2 HRESET = 1'b1;
        #1;
        chk("mid_rst_psel", {31'h0, apb.PSEL}, 32'h0);
        chk("mid_rst_penable", {31'h0, apb.PENABLE}, 32'h0);
        chk("mid_rst_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
        chk("mid_rst_busy", {31'h0, busy_o}, 32'h0);
        @(negedge HCLK);
        HRESET = 1'b0;
        @(negedge HCLK);
        chk("post_rst_ready", {31'h0, req_ready_o}, 32'h1);
        chk("post_rst_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
        do_txn(12'h008, 32'h0, 1'b0, 0, 1'b0, 32'h600DC0DE, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
